// File: rtl/bcd_accumulator_pkg.sv
// Shared constants, FSM state encoding and operand payload type for the
// digit-serial BCD running-total stage.
package bcd_accumulator_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned OPD_W   = 8;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_ADJ = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_pair_t;

  // True when both nibbles of the operand are legal BCD digits.
  function automatic logic bcd_pair_valid(input bcd_pair_t p);
    return (p.tens <= BCD_MAX) && (p.ones <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_accumulator_digit_add.sv
// Combinational single-digit BCD adder: s = a + b + ci with decimal correction.
module bcd_digit_add
  import bcd_accumulator_pkg::*;
(
  input  logic [DIGIT_W-1:0] a_i,
  input  logic [DIGIT_W-1:0] b_i,
  input  logic               ci_i,
  output logic [DIGIT_W-1:0] s_o,
  output logic               co_o
);

  logic [DIGIT_W:0] raw_sum;

  // Worst case 9+9+1=19, so one +6 correction always lands back in 0..9.
  always_comb begin
    raw_sum = (DIGIT_W+1)'(a_i) + (DIGIT_W+1)'(b_i) + (DIGIT_W+1)'(ci_i);
    s_o     = raw_sum[DIGIT_W-1:0];
    co_o    = 1'b0;
    if (raw_sum > (DIGIT_W+1)'(BCD_MAX)) begin
      s_o  = DIGIT_W'(raw_sum + (DIGIT_W+1)'(BCD_ADJ));
      co_o = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_accumulator.sv
// Running BCD total: adds a 2-digit BCD operand plus carry-in one digit per
// clock on each synchronized add-request edge; holds the result for display.
module bcd_accumulator
  import bcd_accumulator_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      CLOCK_50,
  input  logic                      Resetn,
  input  logic                      add_req,
  input  logic                      clear,
  input  logic [OPD_W-1:0]          operand,
  input  logic                      cin,
  output logic [DIGIT_W*DIGITS-1:0] total,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic                      invalid
);

  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_e                      state_q;
  logic [2:0]                  sync_q;
  logic [DIGIT_W*DIGITS-1:0]   total_q;
  bcd_pair_t                   opd_q;
  logic [IDX_W-1:0]            idx_q;
  logic                        carry_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        overflow_q;
  logic                        invalid_q;

  logic                        req_edge_c;
  logic [DIGIT_W-1:0]          tot_digit_c;
  logic [DIGIT_W-1:0]          opd_digit_c;
  logic [DIGIT_W-1:0]          sum_c;
  logic                        co_c;

  assign req_edge_c = sync_q[1] & ~sync_q[2];

  // Select the digit pair being worked on; operand digits above tens are zero.
  always_comb begin
    tot_digit_c = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (idx_q == IDX_W'(d)) tot_digit_c = total_q[d*DIGIT_W +: DIGIT_W];
    end
    opd_digit_c = '0;
    if (idx_q == IDX_W'(0))      opd_digit_c = opd_q.ones;
    else if (idx_q == IDX_W'(1)) opd_digit_c = opd_q.tens;
  end

  bcd_digit_add u_digit_add (
    .a_i  (tot_digit_c),
    .b_i  (opd_digit_c),
    .ci_i (carry_q),
    .s_o  (sum_c),
    .co_o (co_c)
  );

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      total_q    <= '0;
      opd_q      <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], add_req};
      done_q <= 1'b0;
      if (clear) begin
        // Aborts any add in flight and swallows a coincident request edge.
        state_q    <= IDLE;
        total_q    <= '0;
        idx_q      <= '0;
        carry_q    <= 1'b0;
        busy_q     <= 1'b0;
        overflow_q <= 1'b0;
        invalid_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (req_edge_c) begin
              if (!bcd_pair_valid(bcd_pair_t'(operand))) begin
                invalid_q <= 1'b1;
              end else begin
                opd_q   <= bcd_pair_t'(operand);
                carry_q <= cin;
                idx_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= ADD;
              end
            end
          end
          ADD: begin
            for (int unsigned d = 0; d < DIGITS; d++) begin
              if (idx_q == IDX_W'(d)) total_q[d*DIGIT_W +: DIGIT_W] <= sum_c;
            end
            carry_q <= co_c;
            if (idx_q == IDX_LAST) begin
              // Overflow lands together with the done pulse so both are seen at once.
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              overflow_q <= overflow_q | co_c;
              state_q    <= DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign total    = total_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign invalid  = invalid_q;

endmodule
